// File: rtl/ch_buf_seq.sv
// ch_buf_seq: channel-buffer sequencer moving one 1-16 word block between MB and CBUS
// Ports:
//   clk, rst_n                  MBOX clock, asynchronous active-low reset
//   START, CH_NUM, DIR, WC      transfer request; CH_NUM/DIR/WC latched at START (WC=0 means 16)
//   ABORT                       cancel any transfer, return to IDLE on the next edge
//   MB_VALID, MB_ACCEPT         MB-side handshakes (fill for DIR=0, drain for DIR=1)
//   CBUS_REQ                    channel-side request/present
//   CH_BUF_ADR, CH_BUF_WR       buffer address {ch, idx} and write strobe
//   BUF_MB_SEL, CH_BUF_EN       buffer write source (1 = CH_REG) and read enable
//   CH_T0, CH_T2                load MB_CH_BUF from buffer / capture CBUS into CH_REG
//   MB_ACK, CBUS_ACK, MB_RDY    handshake responses
//   BUSY, DONE                  not idle / normal completion pulse
module ch_buf_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       START,
    input  logic [2:0] CH_NUM,
    input  logic       DIR,
    input  logic [3:0] WC,
    input  logic       ABORT,
    input  logic       MB_VALID,
    input  logic       MB_ACCEPT,
    input  logic       CBUS_REQ,
    output logic [6:0] CH_BUF_ADR,
    output logic       CH_BUF_WR,
    output logic       BUF_MB_SEL,
    output logic       CH_BUF_EN,
    output logic       CH_T0,
    output logic       CH_T2,
    output logic       MB_ACK,
    output logic       CBUS_ACK,
    output logic       MB_RDY,
    output logic       BUSY,
    output logic       DONE
);
    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_FCAP, S_FWR, S_DWAIT, S_DOUT, S_DLOAD, S_DRDY, S_DONE
    } state_t;
    state_t     state, state_d;
    logic [2:0] ch, ch_d;
    logic       dir, dir_d;
    logic [3:0] last, last_d, idx, idx_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ch    <= '0;
            dir   <= 1'b0;
            last  <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            ch    <= ch_d;
            dir   <= dir_d;
            last  <= last_d;
            idx   <= idx_d;
        end
    end
    always_comb begin
        state_d = state;
        ch_d    = ch;
        dir_d   = dir;
        last_d  = last;
        idx_d   = idx;
        case (state)
            S_IDLE: if (START && !ABORT) begin
                state_d = S_FILL;
                ch_d    = CH_NUM;
                dir_d   = DIR;
                last_d  = WC - 4'd1;
                idx_d   = '0;
            end
            S_FILL:  if (dir ? CBUS_REQ : MB_VALID) state_d = dir ? S_FCAP : S_FWR;
            S_FCAP:  state_d = S_FWR;
            S_FWR: begin
                state_d = (idx == last) ? (dir ? S_DLOAD : S_DWAIT) : S_FILL;
                idx_d   = (idx == last) ? 4'd0 : idx + 4'd1;
            end
            S_DWAIT: if (CBUS_REQ) state_d = S_DOUT;
            S_DOUT: begin
                state_d = (idx == last) ? S_DONE : S_DWAIT;
                idx_d   = (idx == last) ? idx : idx + 4'd1;
            end
            S_DLOAD: state_d = S_DRDY;
            S_DRDY: if (MB_ACCEPT) begin
                state_d = (idx == last) ? S_DONE : S_DLOAD;
                idx_d   = (idx == last) ? idx : idx + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort beats every transition; START arriving with ABORT in IDLE was already rejected above
        if (ABORT && state != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end
    end
    assign CH_BUF_ADR = (state == S_IDLE) ? 7'd0 : {ch, idx};
    assign CH_BUF_WR  = (state == S_FWR);
    assign BUF_MB_SEL = (state == S_FWR) && dir;
    assign CH_BUF_EN  = (state == S_DWAIT) || (state == S_DOUT) || (state == S_DLOAD) || (state == S_DRDY);
    assign CH_T0      = (state == S_DLOAD);
    assign CH_T2      = (state == S_FCAP);
    assign MB_ACK     = (state == S_FWR) && !dir;
    assign CBUS_ACK   = ((state == S_FWR) && dir) || (state == S_DOUT);
    assign MB_RDY     = (state == S_DRDY);
    assign BUSY       = (state != S_IDLE);
    assign DONE       = (state == S_DONE);
endmodule

// File: tb/tb_ch_buf_seq.sv
// tb_ch_buf_seq: self-checking bench for ch_buf_seq using a transaction-level expectation model
module tb_ch_buf_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, dir = 1'b0, abort = 1'b0;
    logic [2:0] ch_num = '0;
    logic [3:0] wc = '0;
    logic       mb_valid = 1'b0, mb_accept = 1'b0, cbus_req = 1'b0;
    logic [6:0] adr;
    logic       wr, sel, en, t0, t2, mb_ack, cbus_ack, mb_rdy, busy, done;
    logic [16:0] outs;
    int tests = 0, fails = 0;
    logic       clr = 1'b0;
    logic [6:0] wr_q[$], ack_q[$], t0_q[$];
    logic       sel_q[$];
    int         t2_cnt, t2_bad, mb_ack_cnt, busy_cnt, done_cnt;
    int         rdy_cnt[16];
    logic       t2_prev;
    ch_buf_seq dut (
        .clk(clk), .rst_n(rst_n), .START(start), .CH_NUM(ch_num), .DIR(dir), .WC(wc),
        .ABORT(abort), .MB_VALID(mb_valid), .MB_ACCEPT(mb_accept), .CBUS_REQ(cbus_req),
        .CH_BUF_ADR(adr), .CH_BUF_WR(wr), .BUF_MB_SEL(sel), .CH_BUF_EN(en), .CH_T0(t0),
        .CH_T2(t2), .MB_ACK(mb_ack), .CBUS_ACK(cbus_ack), .MB_RDY(mb_rdy), .BUSY(busy), .DONE(done)
    );
    assign outs = {adr, wr, sel, en, t0, t2, mb_ack, cbus_ack, mb_rdy, busy, done};
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (clr) begin
            wr_q.delete(); ack_q.delete(); t0_q.delete(); sel_q.delete();
            t2_cnt <= 0; t2_bad <= 0; mb_ack_cnt <= 0; busy_cnt <= 0; done_cnt <= 0;
            for (int k = 0; k < 16; k++) rdy_cnt[k] <= 0;
            t2_prev <= 1'b0;
        end else begin
            if (wr) begin
                wr_q.push_back(adr);
                sel_q.push_back(sel);
                if (sel && !t2_prev) t2_bad <= t2_bad + 1;
            end
            if (cbus_ack) ack_q.push_back(adr);
            if (t0) t0_q.push_back(adr);
            if (t2) t2_cnt <= t2_cnt + 1;
            if (mb_ack) mb_ack_cnt <= mb_ack_cnt + 1;
            if (mb_rdy) rdy_cnt[adr[3:0]] <= rdy_cnt[adr[3:0]] + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            t2_prev <= t2;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
        step();
    endtask
    // mode 0: handshakes held high; 1: random handshakes; 2: stall MB_ACCEPT 4 cycles on word 1;
    // 3: random handshakes plus stray START pulses carrying other parameters
    task automatic run_xfer(input logic [2:0] c, input logic d, input logic [3:0] w, input int mode);
        int n, cyc, stall;
        n = (w == 4'd0) ? 16 : int'(w);
        stall = 0;
        clear_mon();
        mb_valid = 1'b1; mb_accept = 1'b1; cbus_req = 1'b1;
        ch_num = c; dir = d; wc = w; start = 1'b1;
        step();
        start = 1'b0;
        ch_num = 3'($urandom); dir = 1'($urandom); wc = 4'($urandom);
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (mode == 1 || mode == 3) begin
                mb_valid = 1'($urandom); mb_accept = 1'($urandom); cbus_req = 1'($urandom);
            end
            if (mode == 2) begin
                if (mb_rdy && adr[3:0] == 4'd1 && stall < 4) begin
                    mb_accept = 1'b0;
                    stall++;
                end else mb_accept = 1'b1;
            end
            if (mode == 3) begin
                start = ($urandom_range(0, 2) == 0);
                ch_num = 3'($urandom); dir = 1'($urandom); wc = 4'($urandom);
            end
            step();
            cyc++;
        end
        start = 1'b0;
        step();
        step();
        check("timeout", 32'(cyc < 2000), 32'd1);
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("idle_after", 32'(busy), 32'd0);
        check("wr_cnt", 32'(wr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            check("wr_adr", 32'(wr_q[i]), 32'({c, 4'(i)}));
            check("wr_sel", 32'(sel_q[i]), 32'(d));
        end
        check("ack_cnt", 32'(ack_q.size()), 32'(n));
        for (int i = 0; i < n && i < ack_q.size(); i++)
            check("ack_adr", 32'(ack_q[i]), 32'({c, 4'(i)}));
        check("mb_ack_cnt", 32'(mb_ack_cnt), d ? 32'd0 : 32'(n));
        check("t2_cnt", 32'(t2_cnt), d ? 32'(n) : 32'd0);
        check("t2_before_wr", 32'(t2_bad), 32'd0);
        check("t0_cnt", 32'(t0_q.size()), d ? 32'(n) : 32'd0);
        for (int i = 0; i < t0_q.size() && i < n; i++)
            check("t0_adr", 32'(t0_q[i]), 32'({c, 4'(i)}));
        if (mode == 0) check("busy_cycles", 32'(busy_cnt), d ? 32'(5 * n + 1) : 32'(4 * n + 1));
        if (mode == 2) begin
            check("rdy_word0", 32'(rdy_cnt[0]), 32'd1);
            check("rdy_word1", 32'(rdy_cnt[1]), 32'd5);
            check("rdy_word2", 32'(rdy_cnt[2]), 32'd1);
        end
    endtask
    initial begin
        int cyc;
        step();
        step();
        check("reset_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_outs", 32'(outs), 32'd0);
        run_xfer(3'd5, 1'b0, 4'd2, 0);
        run_xfer(3'd2, 1'b1, 4'd3, 2);
        run_xfer(3'd7, 1'b0, 4'd0, 0);
        run_xfer(3'd1, 1'b1, 4'd4, 0);
        // asynchronous reset while draining
        clear_mon();
        mb_valid = 1'b1; cbus_req = 1'b1; mb_accept = 1'b1;
        ch_num = 3'd6; dir = 1'b0; wc = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!cbus_ack && cyc < 100) begin step(); cyc++; end
        check("reach_dout", 32'(cbus_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs", 32'(outs), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_xfer(3'd6, 1'b0, 4'd4, 0);
        // abort while word 1 of 3 waits in DRDY
        clear_mon();
        ch_num = 3'd4; dir = 1'b1; wc = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!(mb_rdy && adr[3:0] == 4'd1) && cyc < 100) begin step(); cyc++; end
        check("reach_drdy1", 32'(mb_rdy), 32'd1);
        mb_accept = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_outs", 32'(outs), 32'd0);
        step();
        step();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);
        step();
        check("start_abort_stay", 32'(busy), 32'd0);
        for (int t = 0; t < 10; t++)
            run_xfer(3'($urandom), 1'($urandom), 4'($urandom), (t % 2 == 0) ? 1 : 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
